// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: sends a captured pattern MSB-first, repeated, with optional idle gaps.
// Optional macro SEQ_PATTERN_GEN_LFSR_EN fills gap cycles with an LFSR sequence instead of zeros.
module seq_pattern_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [CNT_W-1:0] gap_len,
  input  logic             abort,
  output logic             out_bit,
  output logic             out_valid,
  output logic             exp_det,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t           r_state,     w_state_next;
  logic [PAT_W-1:0] r_pat,       w_pat_next;
  logic [IDX_W-1:0] r_bit_idx,   w_bit_idx_next;
  logic [CNT_W-1:0] r_reps_left, w_reps_left_next;
  logic [CNT_W-1:0] r_gap_len,   w_gap_len_next;
  logic [CNT_W-1:0] r_gap_ctr,   w_gap_ctr_next;
  logic             w_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pat       <= '0;
      r_bit_idx   <= '0;
      r_reps_left <= '0;
      r_gap_len   <= '0;
      r_gap_ctr   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pat       <= w_pat_next;
      r_bit_idx   <= w_bit_idx_next;
      r_reps_left <= w_reps_left_next;
      r_gap_len   <= w_gap_len_next;
      r_gap_ctr   <= w_gap_ctr_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_pat_next       = r_pat;
    w_bit_idx_next   = r_bit_idx;
    w_reps_left_next = r_reps_left;
    w_gap_len_next   = r_gap_len;
    w_gap_ctr_next   = r_gap_ctr;

    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_pat_next       = pattern;
          w_gap_len_next   = gap_len;
          w_reps_left_next = (rep_cnt == '0) ? CNT_ONE : rep_cnt;
          w_bit_idx_next   = IDX_LAST;
          w_state_next     = S_SEND;
        end
      end

      S_SEND: begin
        if (r_bit_idx == '0) begin
          if (r_reps_left == CNT_ONE) begin
            w_state_next = S_DONE;
          end else if (r_gap_len == '0) begin
            // Back-to-back repetition: reload without leaving SEND.
            w_reps_left_next = r_reps_left - CNT_ONE;
            w_bit_idx_next   = IDX_LAST;
          end else begin
            w_reps_left_next = r_reps_left - CNT_ONE;
            w_gap_ctr_next   = r_gap_len;
            w_state_next     = S_GAP;
          end
        end else begin
          w_bit_idx_next = r_bit_idx - 1'b1;
        end
      end

      S_GAP: begin
        w_gap_ctr_next = r_gap_ctr - CNT_ONE;
        if (r_gap_ctr == CNT_ONE) begin
          w_bit_idx_next = IDX_LAST;
          w_state_next   = S_SEND;
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Abort from any active state drops the transmission without a done pulse.
    if (abort && (r_state != S_IDLE)) begin
      w_state_next     = S_IDLE;
      w_bit_idx_next   = '0;
      w_reps_left_next = '0;
      w_gap_ctr_next   = '0;
      w_gap_len_next   = '0;
      w_pat_next       = '0;
    end
  end

`ifdef SEQ_PATTERN_GEN_LFSR_EN
  logic [7:0] r_lfsr;
  logic       w_lfsr_fb;

  // Taps for x^8 + x^6 + x^5 + x^4 + 1; advances only while a gap is on the line.
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 8'hA5;
    end else if (r_state == S_GAP) begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end

  assign w_fill = r_lfsr[0];
`else
  assign w_fill = 1'b0;
`endif

  // All outputs decode registered state only.
  assign out_valid = (r_state == S_SEND);
  assign exp_det   = (r_state == S_SEND) && (r_bit_idx == '0);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign out_bit   = (r_state == S_SEND) ? r_pat[r_bit_idx] :
                     (r_state == S_GAP)  ? w_fill : 1'b0;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: per-cycle expected outputs are queued at stimulus time.
module tb_seq_pattern_gen;
  localparam int PAT_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] rep_cnt = '0;
  logic [CNT_W-1:0] gap_len = '0;
  logic             out_bit, out_valid, exp_det, busy, done;

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
    .rep_cnt(rep_cnt), .gap_len(gap_len), .abort(abort),
    .out_bit(out_bit), .out_valid(out_valid), .exp_det(exp_det),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_tx    = 0;
  logic [4:0] exp_q[$];
  logic [7:0] m_lfsr  = 8'hA5;
  logic [4:0] w_obs;

  // Observed vector: {busy, done, out_valid, out_bit, exp_det}
  assign w_obs = {busy, done, out_valid, out_bit, exp_det};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (busy,done,valid,bit,det) at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: one expected vector per cycle after the start edge.
  always @(posedge clk) begin
    logic [4:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("cyc", 32'(w_obs), 32'(e));
    end
  end

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(5'b00000);
  endtask

  task automatic push_tx(input logic [PAT_W-1:0] pat, input int rep, input int gap);
    int  r;
    logic fill;
    r = (rep == 0) ? 1 : rep;
    for (int i = 0; i < r; i++) begin
      for (int b = PAT_W - 1; b >= 0; b--)
        exp_q.push_back({1'b1, 1'b0, 1'b1, pat[b], (b == 0)});
      if (i < r - 1) begin
        for (int g = 0; g < gap; g++) begin
`ifdef SEQ_PATTERN_GEN_LFSR_EN
          fill   = m_lfsr[0];
          m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`else
          fill = 1'b0;
`endif
          exp_q.push_back({1'b1, 1'b0, 1'b0, fill, 1'b0});
        end
      end
    end
    exp_q.push_back(5'b11000);
    push_idle(2);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic send(input logic [PAT_W-1:0] pat, input int rep, input int gap);
    @(negedge clk);
    pattern = pat;
    rep_cnt = CNT_W'(rep);
    gap_len = CNT_W'(gap);
    start   = 1'b1;
    push_tx(pat, rep, gap);
    @(negedge clk);
    start   = 1'b0;
    pattern = PAT_W'($urandom);
    rep_cnt = CNT_W'($urandom);
    gap_len = CNT_W'($urandom);
    wait_drain("drain");
    n_tx++;
    $display("[TB] tx %0d pattern=%b rep=%0d gap=%0d", n_tx, pat, rep, gap);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held for 10 cycles, then quiet with no start.
    repeat (10) @(negedge clk);
    check_eq("rst_hold", 32'(w_obs), 32'd0);
    rst_n = 1'b1;
    push_idle(5);
    wait_drain("rst_idle");
    $display("[TB] tx reset release idle");

    send(4'b1101, 1, 0);
    send(4'b1101, 3, 0);
    send(4'b1101, 2, 2);
    send(4'b1010, 0, 0);
    send(4'b1011, 2, 3);
    send(4'b0110, 3, 1);

    // Abort mid-send; a second start while busy must be ignored.
    @(negedge clk);
    pattern = 4'b1101; rep_cnt = 8'd1; gap_len = 8'd0; start = 1'b1;
    exp_q.push_back(5'b10110);
    exp_q.push_back(5'b10110);
    push_idle(3);
    @(negedge clk);
    pattern = 4'b0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_drain("abort");
    $display("[TB] tx abort mid-send");

    // Abort and start together in IDLE: start is dropped.
    @(negedge clk);
    pattern = 4'b1111; rep_cnt = 8'd2; start = 1'b1; abort = 1'b1;
    push_idle(4);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    wait_drain("abort_start");
    $display("[TB] tx abort+start in idle");

    // Asynchronous reset during a transmission.
    @(negedge clk);
    pattern = 4'b1101; rep_cnt = 8'd3; gap_len = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async", 32'(w_obs), 32'd0);
    m_lfsr = 8'hA5;
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(4);
    wait_drain("rst_mid");
    $display("[TB] tx async reset mid-send");

    for (int t = 0; t < 6; t++)
      send(PAT_W'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial bit-pattern transmitter. It is the source end of the serial sequence-detector interface: one bit per clock on out_bit, which feeds a detector's in_bit directly.
- Transmits a programmable PAT_W-bit pattern MSB-first, repeated rep_cnt times, with an optional idle gap between repetitions.
- Drives exp_det as a reference strobe, so a bench can compare it against the detector's pattern_det cycle by cycle.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
CNT_W, 8, width of repeat and gap counters

Ports:
clk      input   1      system clock, rising-edge
rst_n    input   1      asynchronous active-low reset
start    input   1      request; accepted only in IDLE
pattern  input   PAT_W  pattern, sampled on accepted start; bit PAT_W-1 sent first
rep_cnt  input   CNT_W  number of transmissions, sampled on start; 0 treated as 1
gap_len  input   CNT_W  fill cycles between repetitions, sampled on start
abort    input   1      synchronous abort, any state
out_bit  output  1      serial data bit
out_valid output 1      1 while a pattern bit is on out_bit
exp_det  output  1      1 in the cycle the last pattern bit is on out_bit
busy     output  1      1 in SEND, GAP and DONE
done     output  1      one-cycle pulse after the final repetition

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, all counters 0, captured pattern 0, all outputs 0.
- Outputs are decoded from registered state only; there is no combinational path from any input to any output.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - Outputs 0.
  - start=1 and abort=0: capture pattern, rep_cnt and gap_len; set bit_idx=PAT_W-1; set reps_left=max(rep_cnt,1); go to SEND.
  - Latency: the first bit appears the cycle after start.
- SEND:
  - out_bit=pat_q[bit_idx], out_valid=1.
  - bit_idx decrements each cycle.
  - exp_det=1 when bit_idx==0.
- At bit_idx==0:
  - If reps_left==1: go to DONE.
  - Else, if gap_len==0: decrement reps_left, reload bit_idx=PAT_W-1, stay in SEND (back-to-back, no bubble).
  - Else: decrement reps_left, load gap_ctr=gap_len, go to GAP.
- GAP:
  - out_valid=0, exp_det=0, out_bit=fill bit (see Optional Feature).
  - gap_ctr decrements each cycle.
  - When gap_ctr==1: reload bit_idx=PAT_W-1 and go to SEND. A gap therefore lasts exactly gap_len cycles.
- DONE: done=1, busy=1, out_valid=0, out_bit=0; lasts one cycle, then IDLE.
- start while busy: ignored; inputs are not re-sampled.
- abort=1 in any non-IDLE state: IDLE next cycle, no done pulse, counters cleared.
- abort and start in the same IDLE cycle: abort wins and start is dropped.
- Input changes after start is accepted have no effect on the transmission in progress.
- rst_n asserted mid-operation: immediate return to IDLE with all outputs 0.
- exp_det marks pattern ends only. Overlaps that form the pattern across repetition or gap boundaries are not flagged.

Optional Feature:
- Macro: SEQ_PATTERN_GEN_LFSR_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) is seeded to 8'hA5 on reset.
  - It shifts once per GAP cycle only.
  - In GAP, out_bit=lfsr[0].
- Undefined: no LFSR logic; out_bit=0 in GAP.
- FSM timing is identical in both builds.

Test Plan:
1. Reset: rst_n=0 for 10 cycles, then release -> out_bit, out_valid, exp_det, busy and done all 0; no activity without start.
2. pattern=4'b1101, rep_cnt=1, gap_len=0, start at cycle 0 -> out_bit=1,1,0,1 in cycles 1-4; out_valid=1 in cycles 1-4; exp_det=1 in cycle 4 only; done=1 in cycle 5; busy=1 in cycles 1-5.
3. pattern=4'b1101, rep_cnt=3, gap_len=0 -> 12 contiguous valid bits; exp_det in cycles 4, 8 and 12; done in cycle 13.
4. pattern=4'b1101, rep_cnt=2, gap_len=2, macro undefined -> bits 1101 00 1101; out_valid=0 in cycles 5-6; exp_det in cycles 4 and 10; done in cycle 11.
5. Start at cycle 0, abort=1 at cycle 2 -> IDLE at cycle 3 with all outputs 0 and no done. A second start at cycle 1 while busy is ignored.
6. rep_cnt=0, pattern=4'b1010 -> a single transmission 1,0,1,0; done in cycle 5. With the macro defined and gap_len=3, rep_cnt=2 -> GAP bits equal the LFSR sequence from seed 8'hA5.
